// File: rtl/perf_event_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_pkg
//  Description : Shared constants for the performance event monitor:
//                readout index map, counter count and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

  // Number of real event counters (index 7 is the status word, not a counter)
  localparam int NUM_CNT     = 7;

  // Readout index map
  localparam int PERF_CYC    = 0;
  localparam int PERF_RET    = 1;
  localparam int PERF_IREQ   = 2;
  localparam int PERF_IHIT   = 3;
  localparam int PERF_DREQ   = 4;
  localparam int PERF_DHIT   = 5;
  localparam int PERF_STALL  = 6;
  localparam int PERF_STATUS = 7;

  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perfState_t;

endpackage
`default_nettype wire

// File: rtl/perf_event_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : perf_event_monitor_if
//  Description : Control, event-strobe and readout bundle of the performance
//                monitor. The master side (pipeline/debug logic) drives the
//                control pulses, event strobes and read requests; the slave
//                side (the monitor) returns readout data and status.
//  Ports       : start, clr, ev_* (event strobes), rd_req, rd_sel  -> monitor
//                rd_valid, rd_data, running, frozen, err          <- monitor
//  Revision    : 1.0 - initial release
// ============================================================================
interface perf_event_monitor_if #(
  parameter int CNT_W = 32
) ();

  logic             start;
  logic             clr;
  logic             ev_retire;
  logic             ev_halt;
  logic             ev_ireq;
  logic             ev_ihit;
  logic             ev_dreq;
  logic             ev_dhit;
  logic             ev_fstall;
  logic             ev_mstall;
  logic             rd_req;
  logic [2:0]       rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             running;
  logic             frozen;
  logic             err;

  modport master (
    output start, clr, ev_retire, ev_halt, ev_ireq, ev_ihit, ev_dreq, ev_dhit,
           ev_fstall, ev_mstall, rd_req, rd_sel,
    input  rd_valid, rd_data, running, frozen, err
  );

  modport slave (
    input  start, clr, ev_retire, ev_halt, ev_ireq, ev_ihit, ev_dreq, ev_dhit,
           ev_fstall, ev_mstall, rd_req, rd_sel,
    output rd_valid, rd_data, running, frozen, err
  );

endinterface
`default_nettype wire

// File: rtl/perf_event_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_sat_counter
//  Description : Saturating event counter. Increments on en, sticks at the
//                all-ones value, synchronous clear has priority over en.
//  Ports       : clk, rst (async active-low), clr, en -> cnt[CNT_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : perf_event_monitor
//  Description : Hardware performance monitor. Counts cycles, retired
//                instructions, I/D-cache requests and qualified hits, and
//                stall cycles while armed; freezes on halt; flags stray hits
//                as a sticky error; offers a registered indexed readout.
//  Ports       : clk          system clock
//                rst          asynchronous active-low reset
//                bus (slave)  control pulses, event strobes, readout, status
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  perf_event_monitor_if.slave  bus
);

  perfState_t       r_state;
  logic             r_running;
  logic             r_frozen;
  logic             r_err;
  logic             r_rdValid;
  logic [CNT_W-1:0] r_rdData;

  logic             w_inRun;
  logic             w_countCycle;
  logic             w_strayHit;
  logic [NUM_CNT-1:0] w_cntEn;
  // Entries 0..6 are the counters, entry 7 is the status word, so the
  // readout mux is a plain index into this array.
  logic [CNT_W-1:0] w_rdSrc [NUM_CNT+1];

  assign w_inRun      = (r_state == ST_RUN);
  // A clr cycle discards every event, so counting is gated by ~clr.
  assign w_countCycle = w_inRun & ~bus.clr;
  assign w_strayHit   = (bus.ev_ihit & ~bus.ev_ireq) | (bus.ev_dhit & ~bus.ev_dreq);

  always_comb begin
    w_cntEn             = '0;
    w_cntEn[PERF_CYC]   = w_countCycle;
    w_cntEn[PERF_RET]   = w_countCycle & bus.ev_retire;
    w_cntEn[PERF_IREQ]  = w_countCycle & bus.ev_ireq;
    w_cntEn[PERF_IHIT]  = w_countCycle & bus.ev_ireq & bus.ev_ihit;
    w_cntEn[PERF_DREQ]  = w_countCycle & bus.ev_dreq;
    w_cntEn[PERF_DHIT]  = w_countCycle & bus.ev_dreq & bus.ev_dhit;
    w_cntEn[PERF_STALL] = w_countCycle & (bus.ev_fstall | bus.ev_mstall);
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.clr),
      .en  (w_cntEn[gi]),
      .cnt (w_rdSrc[gi])
    );
  end

  assign w_rdSrc[PERF_STATUS] = {{(CNT_W-3){1'b0}}, r_err, r_frozen, r_running};

  // State machine; running/frozen are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_frozen  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          // clr outranks a halt retiring in the same cycle
          if (!bus.clr && bus.ev_halt) begin
            r_state   <= ST_FROZEN;
            r_running <= 1'b0;
            r_frozen  <= 1'b1;
          end
        end
        ST_FROZEN: begin
          if (bus.clr) begin
            r_state  <= ST_IDLE;
            r_frozen <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_frozen  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky stray-hit error; clr in the same cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (bus.clr) begin
      r_err <= 1'b0;
    end else if (w_inRun && w_strayHit) begin
      r_err <= 1'b1;
    end
  end

  // Readout samples pre-increment values; data holds between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rdData <= w_rdSrc[bus.rd_sel];
      end
    end
  end

  assign bus.rd_valid = r_rdValid;
  assign bus.rd_data  = r_rdData;
  assign bus.running  = r_running;
  assign bus.frozen   = r_frozen;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_event_monitor
//  Description : Self-checking bench. Drives one stimulus stream into a
//                32-bit and an 8-bit monitor and compares both against an
//                event-counting reference model with unbounded counts that
//                are clipped to each width's maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_monitor;

  localparam int W_A = 32;
  localparam int W_B = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 0, clr = 0, ev_retire = 0, ev_halt = 0, ev_ireq = 0, ev_ihit = 0;
  logic ev_dreq = 0, ev_dhit = 0, ev_fstall = 0, ev_mstall = 0, rd_req = 0;
  logic [2:0] rd_sel = '0;

  perf_event_monitor_if #(.CNT_W(W_A)) busA ();
  perf_event_monitor_if #(.CNT_W(W_B)) busB ();

  assign busA.start = start;     assign busB.start = start;
  assign busA.clr = clr;         assign busB.clr = clr;
  assign busA.ev_retire = ev_retire; assign busB.ev_retire = ev_retire;
  assign busA.ev_halt = ev_halt; assign busB.ev_halt = ev_halt;
  assign busA.ev_ireq = ev_ireq; assign busB.ev_ireq = ev_ireq;
  assign busA.ev_ihit = ev_ihit; assign busB.ev_ihit = ev_ihit;
  assign busA.ev_dreq = ev_dreq; assign busB.ev_dreq = ev_dreq;
  assign busA.ev_dhit = ev_dhit; assign busB.ev_dhit = ev_dhit;
  assign busA.ev_fstall = ev_fstall; assign busB.ev_fstall = ev_fstall;
  assign busA.ev_mstall = ev_mstall; assign busB.ev_mstall = ev_mstall;
  assign busA.rd_req = rd_req;   assign busB.rd_req = rd_req;
  assign busA.rd_sel = rd_sel;   assign busB.rd_sel = rd_sel;

  perf_event_monitor #(.CNT_W(W_A)) dutA (.clk(clk), .rst(rst), .bus(busA));
  perf_event_monitor #(.CNT_W(W_B)) dutB (.clk(clk), .rst(rst), .bus(busB));

  // ---------------- reference model ----------------
  int     mState;
  longint mCnt [7];
  bit     mErr;
  bit     expValid;
  longint expRdA, expRdB;
  int     total = 0;
  int     bad = 0;

  function automatic longint expVal(input int idx, input int w);
    longint cap;
    cap = (longint'(1) << w) - 1;
    if (idx == 7) return (mErr ? 4 : 0) + (mState == M_FROZEN ? 2 : 0) + (mState == M_RUN ? 1 : 0);
    return (mCnt[idx] > cap) ? cap : mCnt[idx];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 7; i++) mCnt[i] = 0;
    mErr = 0;
  endtask

  task automatic modelReset();
    modelClear();
    mState = M_IDLE;
    expValid = 0;
    expRdA = 0;
    expRdB = 0;
  endtask

  task automatic modelStep();
    if (mState == M_IDLE) begin
      if (clr) modelClear();
      if (start) mState = M_RUN;
    end else if (mState == M_RUN) begin
      if (clr) modelClear();
      else begin
        mCnt[0]++;
        if (ev_retire) mCnt[1]++;
        if (ev_ireq) mCnt[2]++;
        if (ev_ireq && ev_ihit) mCnt[3]++;
        if (ev_dreq) mCnt[4]++;
        if (ev_dreq && ev_dhit) mCnt[5]++;
        if (ev_fstall || ev_mstall) mCnt[6]++;
        if ((ev_ihit && !ev_ireq) || (ev_dhit && !ev_dreq)) mErr = 1;
        if (ev_halt) mState = M_FROZEN;
      end
    end else begin
      if (clr) begin
        modelClear();
        mState = M_IDLE;
      end
    end
  endtask

  // One clock: capture expected readout, advance model, step DUT, idle inputs.
  task automatic cycle();
    expValid = rd_req;
    if (rd_req) begin
      expRdA = expVal(int'(rd_sel), W_A);
      expRdB = expVal(int'(rd_sel), W_B);
    end
    modelStep();
    @(posedge clk);
    #1;
    {start, clr, ev_retire, ev_halt, ev_ireq, ev_ihit, ev_dreq, ev_dhit} = '0;
    {ev_fstall, ev_mstall, rd_req} = '0;
  endtask

  task automatic doRead(input int sel);
    rd_req = 1;
    rd_sel = 3'(sel);
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b0;
    modelReset();
    #12;
    total++;
    if (busA.rd_valid !== 1'b0 || busA.rd_data !== 32'd0 || busA.running !== 1'b0 ||
        busA.frozen !== 1'b0 || busA.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_A: valid=%b data=%0h run=%b frz=%b err=%b want all 0",
               busA.rd_valid, busA.rd_data, busA.running, busA.frozen, busA.err);
    end
    total++;
    if (busB.rd_valid !== 1'b0 || busB.rd_data !== 8'd0 || busB.running !== 1'b0 ||
        busB.frozen !== 1'b0 || busB.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_B: valid=%b data=%0h run=%b frz=%b err=%b want all 0",
               busB.rd_valid, busB.rd_data, busB.running, busB.frozen, busB.err);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    // Events in IDLE must not count
    ev_retire = 1; ev_ireq = 1; ev_fstall = 1;
    cycle();
    doRead(0);
    total++;
    if (busA.rd_valid !== 1'b1 || busA.rd_data !== 32'd0) begin
      bad++;
      $display("FAIL idle_no_count: valid=%b data=%0d want 1/0", busA.rd_valid, busA.rd_data);
    end
  endtask

  task automatic test_cycles();
    start = 1;
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    doRead(0);
    total++;
    if (busA.rd_valid !== 1'b1 || busA.rd_data !== 32'd10 || busB.rd_data !== 8'd10) begin
      bad++;
      $display("FAIL cycles10: valid=%b dataA=%0d dataB=%0d want 1/10/10",
               busA.rd_valid, busA.rd_data, busB.rd_data);
    end
    cycle();
    total++;
    if (busA.rd_valid !== 1'b0 || busA.rd_data !== 32'd10) begin
      bad++;
      $display("FAIL valid_one_cycle: valid=%b data=%0d want 0/10 (held)", busA.rd_valid, busA.rd_data);
    end
  endtask

  task automatic test_icache();
    clr = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      ev_ireq = 1;
      ev_ihit = (i < 3);
      cycle();
    end
    doRead(2);
    total++;
    if (busA.rd_data !== 32'd5 || busA.rd_data !== 32'(expRdA)) begin
      bad++;
      $display("FAIL ireq: got %0d want 5", busA.rd_data);
    end
    doRead(3);
    total++;
    if (busA.rd_data !== 32'd3 || busB.rd_data !== 8'd3) begin
      bad++;
      $display("FAIL ihit: gotA %0d gotB %0d want 3", busA.rd_data, busB.rd_data);
    end
    total++;
    if (busA.err !== 1'b0) begin
      bad++;
      $display("FAIL icache_err: got %b want 0", busA.err);
    end
  endtask

  task automatic test_stray_hit();
    ev_dhit = 1;
    ev_dreq = 0;
    cycle();
    doRead(5);
    total++;
    if (busA.rd_data !== 32'd0) begin
      bad++;
      $display("FAIL stray_not_counted: got %0d want 0", busA.rd_data);
    end
    doRead(7);
    total++;
    if (busA.rd_data !== 32'd5 || busA.err !== 1'b1) begin
      bad++;
      $display("FAIL stray_err: status=%0h err=%b want 5/1", busA.rd_data, busA.err);
    end
    clr = 1;
    cycle();
    doRead(0);
    total++;
    if (busA.rd_data !== 32'd0 || busA.err !== 1'b0) begin
      bad++;
      $display("FAIL clr_zero: cyc=%0d err=%b want 0/0", busA.rd_data, busA.err);
    end
    for (int i = 1; i < 7; i++) begin
      doRead(i);
      total++;
      if (busA.rd_data !== 32'(expRdA) || busB.rd_data !== 8'(expRdB)) begin
        bad++;
        $display("FAIL clr_idx%0d: gotA %0d gotB %0d want %0d/%0d", i, busA.rd_data,
                 busB.rd_data, expRdA, expRdB);
      end
    end
  endtask

  task automatic test_saturation();
    clr = 1;
    cycle();
    for (int i = 0; i < 300; i++) cycle();
    doRead(0);
    total++;
    if (busB.rd_data !== 8'd255) begin
      bad++;
      $display("FAIL sat8: got %0d want 255", busB.rd_data);
    end
    total++;
    if (busA.rd_data !== 32'd300) begin
      bad++;
      $display("FAIL cyc32_300: got %0d want 300", busA.rd_data);
    end
    total++;
    if (busB.err !== 1'b0) begin
      bad++;
      $display("FAIL sat_err: got %b want 0", busB.err);
    end
  endtask

  task automatic test_halt();
    clr = 1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      ev_retire = 1;
      cycle();
    end
    ev_retire = 1;
    ev_halt = 1;
    cycle();
    total++;
    if (busA.frozen !== 1'b1 || busA.running !== 1'b0) begin
      bad++;
      $display("FAIL frozen: frz=%b run=%b want 1/0", busA.frozen, busA.running);
    end
    doRead(1);
    total++;
    if (busA.rd_data !== 32'd5) begin
      bad++;
      $display("FAIL retired5: got %0d want 5", busA.rd_data);
    end
    for (int i = 0; i < 20; i++) begin
      ev_retire = 1; ev_ireq = 1; ev_ihit = 1; ev_mstall = 1;
      start = (i == 7);
      cycle();
    end
    doRead(1);
    total++;
    if (busA.rd_data !== 32'd5 || busA.frozen !== 1'b1) begin
      bad++;
      $display("FAIL frozen_hold: ret=%0d frz=%b want 5/1", busA.rd_data, busA.frozen);
    end
    doRead(0);
    total++;
    if (busA.rd_data !== 32'(expRdA)) begin
      bad++;
      $display("FAIL frozen_cyc: got %0d want %0d", busA.rd_data, expRdA);
    end
    clr = 1;
    cycle();
    total++;
    if (busA.running !== 1'b0 || busA.frozen !== 1'b0) begin
      bad++;
      $display("FAIL clr_to_idle: run=%b frz=%b want 0/0", busA.running, busA.frozen);
    end
  endtask

  task automatic test_clr_halt();
    clr = 1;
    start = 1;
    cycle();
    total++;
    if (busA.running !== 1'b1) begin
      bad++;
      $display("FAIL clr_start: run=%b want 1", busA.running);
    end
    ev_retire = 1; ev_halt = 1; clr = 1;
    cycle();
    total++;
    if (busA.running !== 1'b1 || busA.frozen !== 1'b0) begin
      bad++;
      $display("FAIL clr_beats_halt: run=%b frz=%b want 1/0", busA.running, busA.frozen);
    end
    doRead(1);
    total++;
    if (busA.rd_data !== 32'd0) begin
      bad++;
      $display("FAIL clr_halt_discard: ret=%0d want 0", busA.rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      ev_halt   = ($urandom_range(0, 59) == 0);
      ev_retire = 1'($urandom_range(0, 1)) | ev_halt;
      ev_ireq   = 1'($urandom_range(0, 1));
      ev_ihit   = ev_ireq ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      ev_dreq   = 1'($urandom_range(0, 1));
      ev_dhit   = ev_dreq ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      ev_fstall = 1'($urandom_range(0, 1));
      ev_mstall = 1'($urandom_range(0, 1));
      rd_req    = 1'($urandom_range(0, 1));
      rd_sel    = 3'($urandom_range(0, 7));
      cycle();
      total++;
      if (busA.rd_valid !== expValid || busA.rd_data !== 32'(expRdA) ||
          busB.rd_valid !== expValid || busB.rd_data !== 8'(expRdB)) begin
        bad++;
        $display("FAIL rand_rd[%0d]: A=%b/%0d B=%b/%0d want %b/%0d/%0d", i, busA.rd_valid,
                 busA.rd_data, busB.rd_valid, busB.rd_data, expValid, expRdA, expRdB);
      end
      total++;
      if (busA.running !== (mState == M_RUN) || busA.frozen !== (mState == M_FROZEN) ||
          busA.err !== mErr || busB.err !== mErr) begin
        bad++;
        $display("FAIL rand_status[%0d]: run=%b frz=%b errA=%b errB=%b want state=%0d err=%b",
                 i, busA.running, busA.frozen, busA.err, busB.err, mState, mErr);
      end
    end
  endtask

  task automatic test_reset_mid();
    clr = 1;
    cycle();
    start = 1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      ev_retire = 1; ev_fstall = 1;
      cycle();
    end
    doRead(0);
    total++;
    if (busA.rd_valid !== 1'b1 || busA.rd_data !== 32'd6) begin
      bad++;
      $display("FAIL pre_rst_read: valid=%b data=%0d want 1/6", busA.rd_valid, busA.rd_data);
    end
    rd_req = 1;
    rd_sel = 3'd1;
    #2 rst = 1'b0;
    modelReset();
    #1;
    total++;
    if (busA.rd_valid !== 1'b0 || busA.rd_data !== 32'd0 || busA.running !== 1'b0 ||
        busB.rd_valid !== 1'b0 || busB.rd_data !== 8'd0) begin
      bad++;
      $display("FAIL async_rst: validA=%b dataA=%0d run=%b validB=%b dataB=%0d want 0",
               busA.rd_valid, busA.rd_data, busA.running, busB.rd_valid, busB.rd_data);
    end
    rd_req = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev_retire = 1; ev_ireq = 1; ev_dreq = 1; ev_mstall = 1;
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      doRead(i);
      total++;
      if (busA.rd_valid !== 1'b1 || busA.rd_data !== 32'd0 || busB.rd_data !== 8'd0) begin
        bad++;
        $display("FAIL post_rst_idx%0d: valid=%b A=%0d B=%0d want 1/0/0", i,
                 busA.rd_valid, busA.rd_data, busB.rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cycles();
    test_icache();
    test_stray_hit();
    test_saturation();
    test_halt();
    test_clr_halt();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Hardware performance-monitor stage that consumes the per-cycle retire and cache-event strobes produced by the pipeline and cache probe points.
- Accumulates saturating event counts for cycles, retired instructions, I-cache requests/hits and D-cache requests/hits, plus fetch/memory stall cycles.
- Freezes all counts when the processor halts.
- Provides a registered, one-cycle-latency indexed readout port for the debug/trace logic downstream.

Parameters:
- CNT_W, 32, width of every event counter; legal range 8..32.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; all state clears while low.
- start  in  1  pulse; arms counting (IDLE->RUN).
- clr  in  1  pulse; zeroes all counters and the error flag.
- ev_retire  in  1  instruction retired this cycle (regwrite | memwrite | halt, already stall-qualified).
- ev_halt  in  1  halt instruction retiring this cycle.
- ev_ireq  in  1  valid I-cache request.
- ev_ihit  in  1  I-cache hit.
- ev_dreq  in  1  valid D-cache request.
- ev_dhit  in  1  D-cache hit.
- ev_fstall  in  1  fetch stall asserted.
- ev_mstall  in  1  memory stall asserted.
- rd_req  in  1  readout request.
- rd_sel  in  3  counter index.
- rd_valid  out  1  rd_data valid.
- rd_data  out  CNT_W  selected value.
- running  out  1  state==RUN.
- frozen  out  1  state==FROZEN.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: all counters 0, state IDLE, rd_valid=0, rd_data=0, err=0, running=0, frozen=0.
- Counter indices:
  - 0 cycles
  - 1 retired
  - 2 ireq
  - 3 ihit
  - 4 dreq
  - 5 dhit
  - 6 stall (counts cycles with ev_fstall|ev_mstall; one count per cycle even if both are set)
  - 7 status word: {zero-pad, err, frozen, running}.
- FSM states: IDLE, RUN, FROZEN.
  - IDLE: no counting; start -> RUN (counting begins the cycle after start).
  - RUN: every cycle, cycles+1 and each qualified event +1; ev_halt -> FROZEN. The halt cycle itself is counted (cycles, retired if ev_retire).
  - FROZEN: counters hold. clr -> IDLE with counters zeroed. start is ignored.
- clr in RUN: counters zero next cycle; state stays RUN; all events in the clr cycle are discarded.
- clr and ev_halt in the same RUN cycle: clr wins; halt is ignored; state stays RUN.
- clr and start in the same IDLE cycle: zero counters and go to RUN.
- Hit qualification: ihit counts only with ireq in the same cycle; dhit counts only with dreq.
- ev_ihit without ev_ireq, or ev_dhit without ev_dreq, in RUN sets err (sticky until clr or rst); that stray hit is not counted.
- Saturation: each counter stops at 2^CNT_W-1 and never wraps; err is not set on saturation.
- Readout:
  - rd_req in cycle N -> rd_valid=1 and rd_data=value in cycle N+1.
  - The value is the counter before cycle N's increment.
  - One request per cycle, back-to-back permitted.
  - rd_valid is 0 in any cycle not following an rd_req.
  - rd_data holds its last value when rd_valid=0.
  - Readout is legal in every state.
- Reset mid-operation: rst low clears everything asynchronously, including a pending rd_valid. Release is taken synchronously at the next clk edge.

Decomposition:
- Shared package perf_pkg: counter index constants (PERF_CYC..PERF_STATUS), state encoding constants, NUM_CNT=7.
- One sub-module perf_sat_counter (CNT_W): inputs clr, en; output cnt; saturating increment. Instantiated 7 times.
- FSM, qualification, error flag and readout mux live in the top module.

Test Plan:
- Reset, then start, then 10 idle RUN cycles; read index 0 -> rd_data=10 one cycle after rd_req, rd_valid high exactly one cycle.
- 5 cycles with ev_ireq=1, of which 3 also have ev_ihit=1 -> idx2=5, idx3=3, err=0.
- ev_dhit=1 with ev_dreq=0 for one cycle -> idx5 unchanged, status bit2 (err)=1; subsequent clr -> err=0, all counters 0.
- CNT_W=8: 300 RUN cycles -> idx0=255, with no wrap to 44.
- ev_retire=1 for 4 cycles, then ev_halt+ev_retire -> idx1=5, frozen=1; 20 more event cycles -> idx1 still 5; clr -> IDLE, running=0.
- rst low mid-RUN, concurrent with an rd_req -> rd_valid=0 and all counters 0 immediately; after release, state is IDLE and events are not counted until start.
